// File: rtl/sha256_digest_if.sv
// rtl/sha256_digest_if.sv - Message-in / digest-out handshake bundle for sha256_digest
interface sha256_digest_if #(
    parameter int MAX_BLOCKS = 20
);
    localparam int NBW = $clog2(MAX_BLOCKS + 1);

    logic                      in_valid;
    logic                      in_ready;
    logic [NBW-1:0]            num_blocks;
    logic [MAX_BLOCKS*512-1:0] message_in;
    logic [255:0]              digest;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_valid, num_blocks, message_in, out_ready,
        input  in_ready, digest, out_valid
    );

    modport slave (
        input  in_valid, num_blocks, message_in, out_ready,
        output in_ready, digest, out_valid
    );
endinterface

// File: rtl/sha256_digest.sv
// rtl/sha256_digest.sv - Iterative multi-block SHA-256 engine, one round per cycle.
// Optional macro SHA256_FR_TRUNC_EN clears digest bits [7:6] for BLS12-381 Fr labels.
module sha256_digest #(
    parameter int MAX_BLOCKS = 20
) (
    input  logic            clk,
    input  logic            rst,
    sha256_digest_if.slave  bus
);
    localparam int NBW  = $clog2(MAX_BLOCKS + 1);
    localparam int MSGW = MAX_BLOCKS * 512;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, ADD, DONE} state_t;

    state_t          state, state_next;
    logic [MSGW-1:0] msg;
    logic [31:0]     hv [8];
    logic [31:0]     wv [8];
    logic [31:0]     w  [16];
    logic [5:0]      t;
    logic [NBW-1:0]  blk;
    logic [NBW-1:0]  nb_clamped;
    logic [255:0]    digest_r;
    logic [255:0]    h_sum;
    logic [255:0]    digest_next;
    logic [511:0]    blk_data;
    logic [31:0]     t1, t2, w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    assign nb_clamped = (bus.num_blocks == '0 || bus.num_blocks > NBW'(MAX_BLOCKS))
                      ? NBW'(MAX_BLOCKS) : bus.num_blocks;
    assign blk_data   = msg[{blk, 9'd0} +: 512];

    always_comb begin
        t1 = wv[7]
           + (rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25))
           + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6]))
           + K[t] + w[0];
        t2 = (rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22))
           + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
        w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10))
              + w[9]
              + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3))
              + w[0];
        h_sum = '0;
        for (int i = 0; i < 8; i++) begin
            h_sum[255-32*i -: 32] = hv[i] + wv[i];
        end
    end

`ifdef SHA256_FR_TRUNC_EN
    assign digest_next = {h_sum[255:8], 2'b00, h_sum[5:0]};
`else
    assign digest_next = h_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = LOAD;
            LOAD:    state_next = ROUND;
            ROUND:   if (t == 6'd63) state_next = ADD;
            ADD:     state_next = (blk == '0) ? DONE : LOAD;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Blocks are hashed from the top of the right-aligned message down to block 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            digest_r <= '0;
            t        <= '0;
            blk      <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    msg <= bus.message_in;
                    blk <= nb_clamped - 1'b1;
                    for (int i = 0; i < 8; i++) hv[i] <= IV[i];
                end
                LOAD: begin
                    for (int i = 0; i < 8; i++)  wv[i] <= hv[i];
                    for (int i = 0; i < 16; i++) w[i]  <= blk_data[511-32*i -: 32];
                    t <= '0;
                end
                ROUND: begin
                    wv[0] <= t1 + t2;
                    wv[1] <= wv[0];
                    wv[2] <= wv[1];
                    wv[3] <= wv[2];
                    wv[4] <= wv[3] + t1;
                    wv[5] <= wv[4];
                    wv[6] <= wv[5];
                    wv[7] <= wv[6];
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_new;
                    t     <= t + 1'b1;
                end
                ADD: begin
                    for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wv[i];
                    if (blk == '0) digest_r <= digest_next;
                    else           blk      <= blk - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.digest    = digest_r;
endmodule

// File: tb/tb_sha256_digest.sv
// tb/tb_sha256_digest.sv - Self-checking bench for sha256_digest: golden vectors, corner sequences, random vs model.
module tb_sha256_digest;
    localparam int MAXB = 20;
    localparam int MSGW = MAXB * 512;
    localparam int NBW  = $clog2(MAXB + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha256_digest_if #(.MAX_BLOCKS(MAXB)) bus ();
    sha256_digest #(.MAX_BLOCKS(MAXB)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] H0 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef struct {
        string           name;
        logic [MSGW-1:0] msg;
        logic [NBW-1:0]  nb;
        logic [255:0]    exp;
        int              lat;
    } vec_t;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] fr(input logic [255:0] d);
        logic [255:0] r;
        r = d;
`ifdef SHA256_FR_TRUNC_EN
        r[7:6] = 2'b00;
`endif
        return r;
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook FIPS 180-4 model: full 64-word schedule per block, blocks taken top-down.
    function automatic logic [255:0] ref_digest(input logic [MSGW-1:0] m, input int n);
        logic [31:0]  hh [8];
        logic [31:0]  v  [8];
        logic [31:0]  ws [64];
        logic [31:0]  x1, x2;
        logic [511:0] b;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) hh[i] = H0[i];
        for (int bi = n - 1; bi >= 0; bi--) begin
            b = m[bi*512 +: 512];
            for (int i = 0; i < 64; i++) begin
                if (i < 16) ws[i] = b[511-32*i -: 32];
                else ws[i] = ws[i-16] + (ror(ws[i-15], 7) ^ ror(ws[i-15], 18) ^ (ws[i-15] >> 3))
                           + ws[i-7] + (ror(ws[i-2], 17) ^ ror(ws[i-2], 19) ^ (ws[i-2] >> 10));
            end
            for (int i = 0; i < 8; i++) v[i] = hh[i];
            for (int i = 0; i < 64; i++) begin
                x1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + ws[i];
                x2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int j = 7; j > 0; j--) v[j] = v[j-1];
                v[4] = v[4] + x1;
                v[0] = x1 + x2;
            end
            for (int i = 0; i < 8; i++) hh[i] = hh[i] + v[i];
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hh[i];
        return fr(r);
    endfunction

    function automatic logic [MSGW-1:0] rand_fill();
        logic [MSGW-1:0] m;
        for (int i = 0; i < MSGW / 32; i++) m[i*32 +: 32] = $urandom;
        return m;
    endfunction

    task automatic send(input string name, input logic [MSGW-1:0] m, input logic [NBW-1:0] nb);
        @(negedge clk);
        check({name, " in_ready idle"}, 256'(bus.in_ready), 256'(1));
        bus.message_in = m;
        bus.num_blocks = nb;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.message_in = rand_fill();
    endtask

    task automatic wait_out(input int budget, output int lat, output bit rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (lat < budget) begin
            @(posedge clk);
            #1 lat++;
            if (bus.in_ready) rdy_seen = 1'b1;
            if (bus.out_valid) break;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic run_vector(input string name, input logic [MSGW-1:0] m, input logic [NBW-1:0] nb,
                              input logic [255:0] exp, input int explat);
        int lat;
        bit seen;
        send(name, m, nb);
        wait_out(explat + 20, lat, seen);
        check({name, " latency"}, 256'(lat), 256'(explat));
        check({name, " digest"}, bus.digest, exp);
        check({name, " in_ready while busy"}, 256'(seen), 256'(0));
        take();
        check({name, " out_valid/in_ready after handshake"}, {bus.out_valid, bus.in_ready}, 256'(2'b01));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            vecs [3];
        logic [MSGW-1:0] m;
        logic [447:0]    s;
        logic [255:0]    d0;
        logic [255:0]    exp_abc, exp_empty;
        int              lat, n;
        bit              seen, ok;

        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.num_blocks = '0; bus.message_in = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 256'(bus.in_ready), 256'(0));
        check("reset out_valid", 256'(bus.out_valid), 256'(0));
        check("reset digest", bus.digest, 256'(0));
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check("in_ready after reset", 256'(bus.in_ready), 256'(1));

        exp_abc   = fr(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        exp_empty = fr(256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);

        m = rand_fill(); m[511:0] = '0; m[511:480] = 32'h61626380; m[31:0] = 32'h18;
        vecs[0] = '{name: "abc", msg: m, nb: NBW'(1), exp: exp_abc, lat: 66};
        m = rand_fill(); m[511:0] = '0; m[511:480] = 32'h80000000;
        vecs[1] = '{name: "empty", msg: m, nb: NBW'(1), exp: exp_empty, lat: 66};
        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        m = rand_fill(); m[1023:0] = '0; m[1023 -: 448] = s; m[575 -: 8] = 8'h80; m[31:0] = 32'h1c0;
        vecs[2] = '{name: "two-block", msg: m, nb: NBW'(2),
                    exp: fr(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1), lat: 132};

        for (int i = 0; i < 3; i++)
            run_vector(vecs[i].name, vecs[i].msg, vecs[i].nb, vecs[i].exp, vecs[i].lat);

        // Backpressure in DONE, then two back-to-back "abc" messages.
        send("bp", vecs[0].msg, NBW'(1));
        wait_out(100, lat, seen);
        d0 = bus.digest;
        check("bp digest", d0, exp_abc);
        ok = 1'b1;
        repeat (50) begin
            @(posedge clk);
            #1 if (bus.digest !== d0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) ok = 1'b0;
        end
        check("bp held stable", 256'(ok), 256'(1));
        take();
        check("bp in_ready after release", 256'(bus.in_ready), 256'(1));
        repeat (5) @(posedge clk);
        #1 check("digest held in idle", bus.digest, exp_abc);
        run_vector("abc back-to-back 1", vecs[0].msg, NBW'(1), exp_abc, 66);
        run_vector("abc back-to-back 2", vecs[0].msg, NBW'(1), exp_abc, 66);

        // Reset asserted for one cycle while round 30 is in progress.
        send("rst-mid", vecs[0].msg, NBW'(1));
        repeat (31) @(posedge clk);
        #1 rst = 1'b1;
        check("in_ready during mid reset", 256'(bus.in_ready), 256'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        ok = 1'b1;
        repeat (100) begin
            @(posedge clk);
            #1 if (bus.out_valid) ok = 1'b0;
        end
        check("no output after mid reset", 256'(ok), 256'(1));
        run_vector("empty after reset", vecs[1].msg, NBW'(1), exp_empty, 66);

        // Out-of-range counts clamp to MAX_BLOCKS.
        m = rand_fill();
        run_vector("clamp nb=0", m, NBW'(0), ref_digest(m, MAXB), 66 * MAXB);
        m = rand_fill();
        run_vector("clamp nb=25", m, NBW'(25), ref_digest(m, MAXB), 66 * MAXB);

        for (int it = 0; it < 6; it++) begin
            m = rand_fill();
            n = $urandom_range(1, 4);
            run_vector($sformatf("random %0d n=%0d", it, n), m, NBW'(n), ref_digest(m, n), 66 * n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
